// File: rtl/controlador_autenticacao.sv
// Sequencer for the 6-input authentication comparator: latches a code, waits for the
// match lines to settle, then grants or denies. Lockout is built only with FAIL_LOCKOUT_EN.
module controlador_autenticacao #(
  parameter int MAX_TRIES     = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int GRANT_CYCLES  = 8,
  parameter int LOCK_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] code_in,
  input  logic [2:0] aut_in,
  output logic [5:0] cmp_code,
  output logic       busy,
  output logic       grant,
  output logic       deny,
  output logic [1:0] level,
  output logic       locked,
  output logic [3:0] fail_cnt
);

  localparam int MAX_CYC_A = (SETTLE_CYCLES > GRANT_CYCLES) ? SETTLE_CYCLES : GRANT_CYCLES;
  localparam int MAX_CYC   = (MAX_CYC_A > LOCK_CYCLES) ? MAX_CYC_A : LOCK_CYCLES;
  localparam int TW        = $clog2(MAX_CYC + 1);

  generate
    if (MAX_TRIES < 1 || MAX_TRIES > 15 || SETTLE_CYCLES < 1 ||
        GRANT_CYCLES < 1 || LOCK_CYCLES < 1) begin : g_param_check
      $error("controlador_autenticacao: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    EVAL,
    GRANT,
    DENY
`ifdef FAIL_LOCKOUT_EN
    , LOCK
`endif
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      cmp_code <= '0;
      busy     <= 1'b0;
      grant    <= 1'b0;
      deny     <= 1'b0;
      level    <= 2'd0;
      locked   <= 1'b0;
      fail_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cmp_code <= code_in;
            timer    <= TW'(SETTLE_CYCLES - 1);
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end

        SETTLE: begin
          if (timer == '0) state <= EVAL;
          else             timer <= timer - TW'(1);
        end

        EVAL: begin
          if (|aut_in) begin
            // Highest-numbered match line wins.
            level    <= aut_in[2] ? 2'd3 : (aut_in[1] ? 2'd2 : 2'd1);
            fail_cnt <= 4'd0;
            timer    <= TW'(GRANT_CYCLES - 1);
            grant    <= 1'b1;
            state    <= GRANT;
          end else begin
            if (fail_cnt != 4'hf) fail_cnt <= fail_cnt + 4'd1;
            deny  <= 1'b1;
            state <= DENY;
          end
        end

        GRANT: begin
          if (timer == '0) begin
            grant <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        DENY: begin
          deny  <= 1'b0;
          level <= 2'd0;
`ifdef FAIL_LOCKOUT_EN
          // fail_cnt already holds the count including this deny.
          if (fail_cnt >= 4'(MAX_TRIES)) begin
            timer  <= TW'(LOCK_CYCLES - 1);
            locked <= 1'b1;
            state  <= LOCK;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
`else
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end

`ifdef FAIL_LOCKOUT_EN
        LOCK: begin
          if (timer == '0) begin
            locked   <= 1'b0;
            fail_cnt <= 4'd0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
`endif

        default: begin
          busy   <= 1'b0;
          grant  <= 1'b0;
          deny   <= 1'b0;
          locked <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_autenticacao.sv
// Scoreboard bench for controlador_autenticacao: stimulus queues expected grant/deny
// responses, a monitor pops and compares them as the DUT produces them.
module tb_controlador_autenticacao;

  localparam int GRANT_CYCLES = 8;
  localparam int LOCK_CYCLES  = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] code_in;
  logic [2:0] aut_in;
  logic [5:0] cmp_code;
  logic       busy, grant, deny, locked;
  logic [1:0] level;
  logic [3:0] fail_cnt;

  controlador_autenticacao #(
    .MAX_TRIES(3), .SETTLE_CYCLES(2), .GRANT_CYCLES(GRANT_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .code_in(code_in), .aut_in(aut_in),
    .cmp_code(cmp_code), .busy(busy), .grant(grant), .deny(deny), .level(level),
    .locked(locked), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_grant;
    logic [1:0] lvl;
    logic [3:0] fc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples just after each rising edge, pops on each grant rise or deny pulse.
  logic grant_q = 1'b0, deny_q = 1'b0;
  int   grant_len = 0;
  exp_t e;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      grant_q   = 1'b0;
      deny_q    = 1'b0;
      grant_len = 0;
    end else begin
      if (grant && deny) check("grant_deny_overlap", {31'd0, deny}, 32'd0);
      if ((grant && !grant_q) || (deny && !deny_q)) begin
        if (sb.size() == 0) begin
          check("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_kind", {31'd0, grant}, {31'd0, e.is_grant});
          if (e.is_grant) check("resp_level", {30'd0, level}, {30'd0, e.lvl});
          check("resp_fail_cnt", {28'd0, fail_cnt}, {28'd0, e.fc});
          $display("response %s level=%0d fail_cnt=%0d", grant ? "grant" : "deny", level, fail_cnt);
        end
      end
      if (deny && deny_q) check("deny_width", 32'd2, 32'd1);
      if (grant) begin
        grant_len++;
      end else if (grant_q) begin
        check("grant_len", grant_len, GRANT_CYCLES);
        grant_len = 0;
      end
      grant_q = grant;
      deny_q  = deny;
    end
  end

  // Issue one request; returns at the negedge where grant or deny is first visible.
  task automatic run(input logic [5:0] code, input logic [2:0] aut, input logic g,
                     input logic [1:0] lvl, input logic [3:0] fc);
    exp_t x;
    int   n;
    @(negedge clk);
    code_in = code;
    aut_in  = aut;
    start   = 1'b1;
    x.is_grant = g; x.lvl = lvl; x.fc = fc;
    sb.push_back(x);
    $display("request code=%b aut=%b expect %s", code, aut, g ? "grant" : "deny");
    @(negedge clk);
    start = 1'b0;
    check("cmp_code_capture", {26'd0, cmp_code}, {26'd0, code});
    check("busy_after_start", {31'd0, busy}, 32'd1);
    n = 1;
    while (!(grant || deny) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 4);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; code_in = '0; aut_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmp_code", {26'd0, cmp_code}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {31'd0, grant}, 32'd0);
    check("rst_deny", {31'd0, deny}, 32'd0);
    check("rst_level", {30'd0, level}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_fail_cnt", {28'd0, fail_cnt}, 32'd0);

    // Single grant, then priority encoding.
    run(6'b011000, 3'b001, 1'b1, 2'd1, 4'd0);
    wait_idle();
    check("level_hold_1", {30'd0, level}, 32'd1);
    check("cmp_code_hold", {26'd0, cmp_code}, {26'd0, 6'b011000});
    run(6'b101010, 3'b110, 1'b1, 2'd3, 4'd0);
    wait_idle();
    check("level_hold_3", {30'd0, level}, 32'd3);
    run(6'b000111, 3'b010, 1'b1, 2'd2, 4'd0);
    wait_idle();
    check("level_hold_2", {30'd0, level}, 32'd2);

`ifdef FAIL_LOCKOUT_EN
    for (int i = 1; i <= 3; i++) begin
      run({3'b100, 3'(i)}, 3'b000, 1'b0, 2'd0, 4'(i));
      @(negedge clk);
      if (i < 3) begin
        check("deny_busy_clear", {31'd0, busy}, 32'd0);
        check("deny_level_clear", {30'd0, level}, 32'd0);
        check("deny_not_locked", {31'd0, locked}, 32'd0);
      end else begin
        int l;
        check("lock_entered", {31'd0, locked}, 32'd1);
        check("lock_fail_cnt", {28'd0, fail_cnt}, 32'd3);
        code_in = 6'h3f;
        start   = 1'b1;
        l = 1;
        @(negedge clk);
        start = 1'b0;
        l++;
        while (locked && l < 100) begin
          @(negedge clk);
          l++;
        end
        check("lock_length", l - 1, LOCK_CYCLES);
        check("lock_exit_busy", {31'd0, busy}, 32'd0);
        check("lock_exit_fail_cnt", {28'd0, fail_cnt}, 32'd0);
        check("lock_start_ignored", {26'd0, cmp_code}, {26'd0, 6'b100011});
        @(negedge clk);
        check("lock_start_not_queued", {31'd0, busy}, 32'd0);
      end
    end
`else
    for (int i = 1; i <= 5; i++) begin
      run({3'b100, 3'(i)}, 3'b000, 1'b0, 2'd0, 4'(i));
      @(negedge clk);
      check("deny_busy_clear", {31'd0, busy}, 32'd0);
      check("deny_not_locked", {31'd0, locked}, 32'd0);
      check("deny_fail_cnt", {28'd0, fail_cnt}, i);
    end
    run(6'b010101, 3'b001, 1'b1, 2'd1, 4'd0);
    wait_idle();
`endif

    // Reset in the third grant cycle, then an immediate new request.
    run(6'b110011, 3'b100, 1'b1, 2'd3, 4'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_grant", {31'd0, grant}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cmp_code", {26'd0, cmp_code}, 32'd0);
    check("midrst_level", {30'd0, level}, 32'd0);
    reset = 1'b0;
    run(6'b001100, 3'b011, 1'b1, 2'd2, 4'd0);
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
